// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake, redirect from execute and the decode-side
// FIFO head. The fetch unit connects through the master modport.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem reads, and a small {pc, word} FIFO
// feeding decode. A redirect reloads the PC, empties the FIFO and drops any in-flight word.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     flight_pc_q, flight_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     pc_mem_q   [DEPTH];
  logic [31:0]     word_mem_q [DEPTH];
  logic            granted, push, pop;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  always_comb begin
    granted = (state_q == StReq) && bus.imem_gnt;
    push    = (state_q == StWait) && bus.imem_rvalid && !bus.redirect;
    pop     = (count_q != '0) && bus.instr_ready;
  end

  // A redirect empties the FIFO outright, so a coincident pop has no effect.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    flight_pc_d = flight_pc_q;
    if (granted) begin
      flight_pc_d = fetch_pc_q;
      fetch_pc_d  = fetch_pc_q + 32'd4;
    end
    if (bus.redirect) fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
  end

  always_comb begin
    state_d = state_q;
    if (bus.redirect) begin
      unique case (state_q)
        StIdle:  state_d = StReq;
        StReq:   state_d = bus.imem_gnt ? StDrop : StReq;
        StWait:  state_d = bus.imem_rvalid ? StReq : StDrop;
        StDrop:  state_d = bus.imem_rvalid ? StReq : StDrop;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle:  if (count_q < Full) state_d = StReq;
        StReq:   if (bus.imem_gnt) state_d = StWait;
        StWait:  if (bus.imem_rvalid) state_d = (count_d < Full) ? StReq : StIdle;
        StDrop:  if (bus.imem_rvalid) state_d = StReq;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bus.imem_req    = (state_q == StReq);
    bus.imem_addr   = fetch_pc_q;
    bus.instr_valid = (count_q != '0);
    bus.instr       = word_mem_q[rd_ptr_q];
    bus.instr_pc    = pc_mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      flight_pc_q <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      flight_pc_q <= flight_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem_q[wr_ptr_q]   <= flight_pc_q;
      word_mem_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-configurable memory responder, directed scenarios
// and a randomized phase, all checked against an expected-PC stream scoreboard.
module tb_fetch_unit;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned Depth   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC(ResetPc),
    .DEPTH   (Depth)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;
  int pops   = 0;

  // Program image: each address holds a distinct word.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: actual %h required %h", name, act, req);
  endtask

  // Expected decode stream: consecutive PCs from the last reset/redirect target.
  logic [31:0] exp_q[$];
  logic [31:0] next_pc;

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    next_pc = {pc[31:2], 2'b00};
    topup();
  endtask

  // Memory responder.
  bit          rand_mem = 1'b0;
  int          g_fix = 0, l_fix = 0;
  int          gcnt = 0, gdelay = 0, lat_left = 0;
  bit          pending = 1'b0, busy = 1'b0;
  logic [31:0] paddr;

  task automatic set_mem(input bit r, input int g, input int l);
    rand_mem = r;
    g_fix    = g;
    l_fix    = l;
    gdelay   = g;
    gcnt     = 0;
  endtask

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      busy            = pending;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (pending) begin
        if (lat_left == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = word_of(paddr);
          pending         = 1'b0;
        end else begin
          lat_left--;
        end
      end
      if (bus.imem_req && !busy) begin
        if (gcnt >= gdelay) begin
          bus.imem_gnt = 1'b1;
          pending      = 1'b1;
          paddr        = bus.imem_addr;
          lat_left     = rand_mem ? int'($urandom_range(0, 3)) : l_fix;
          gdelay       = rand_mem ? int'($urandom_range(0, 3)) : g_fix;
          gcnt         = 0;
        end else begin
          gcnt++;
        end
      end
    end
  end

  // Monitor: protocol check plus scoreboard compare on every consumed instruction.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.imem_req)
        check(!busy, "one_outstanding", {31'd0, busy}, 32'd0);
      if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
        check(exp_q.size() != 0, "exp_queue_nonempty", exp_q.size(), 32'd1);
        if (exp_q.size() != 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check(bus.instr_pc == e, "pop_pc", bus.instr_pc, e);
          check(bus.instr == word_of(e), "pop_word", bus.instr, word_of(e));
          pops++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    topup();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    restart(ResetPc);
    step();
    check(bus.imem_req == 1'b0, "reset_req", {31'd0, bus.imem_req}, 32'd0);
    check(bus.instr_valid == 1'b0, "reset_valid", {31'd0, bus.instr_valid}, 32'd0);
    repeat (6) step();
    reset = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    restart(pc);
    step();
    bus.redirect = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1);
  end

  initial begin
    int  p0;
    bit  found;
    int  thr;
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b0;
    restart(ResetPc);

    // 1-cycle memory, decode always ready.
    set_mem(1'b0, 0, 0);
    bus.instr_ready = 1'b1;
    do_reset();
    check(bus.imem_req == 1'b0, "c0_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    check(bus.imem_req == 1'b1, "c1_req", {31'd0, bus.imem_req}, 32'd1);
    check(bus.imem_addr == ResetPc, "c1_addr", bus.imem_addr, ResetPc);
    step();
    check(bus.instr_valid == 1'b0, "c2_valid", {31'd0, bus.instr_valid}, 32'd0);
    step();
    check(bus.instr_valid == 1'b1, "c3_valid", {31'd0, bus.instr_valid}, 32'd1);
    check(bus.instr_pc == ResetPc, "c3_pc", bus.instr_pc, ResetPc);
    p0 = pops;
    repeat (8) step();
    check(pops - p0 == 4, "throughput", pops - p0, 32'd4);

    // Decode stalled: FIFO fills to Depth and fetch stops.
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (12) step();
    check(bus.instr_valid == 1'b1, "full_valid", {31'd0, bus.instr_valid}, 32'd1);
    check(bus.instr_pc == ResetPc, "full_head", bus.instr_pc, ResetPc);
    repeat (4) begin
      check(bus.imem_req == 1'b0, "full_no_req", {31'd0, bus.imem_req}, 32'd0);
      step();
    end
    bus.instr_ready = 1'b1;
    step();
    step();
    check(bus.instr_valid == 1'b0, "drained_two", {31'd0, bus.instr_valid}, 32'd0);
    check(bus.imem_req == 1'b1, "resume_req", {31'd0, bus.imem_req}, 32'd1);
    check(bus.imem_addr == ResetPc + 32'd8, "resume_addr", bus.imem_addr, ResetPc + 32'd8);

    // Slow grant and response: address held until grant.
    set_mem(1'b0, 4, 2);
    bus.instr_ready = 1'b0;
    do_reset();
    step();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      check(bus.imem_req && bus.imem_addr == ResetPc, "addr_stable", bus.imem_addr, ResetPc);
      if (bus.imem_gnt) found = 1'b1;
      else step();
    end
    check(found, "slow_grant_seen", {31'd0, found}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.instr_valid) found = 1'b1;
    end
    check(found, "slow_word_seen", {31'd0, found}, 32'd1);
    check(bus.instr_pc == ResetPc, "slow_pc", bus.instr_pc, ResetPc);
    check(bus.instr == word_of(ResetPc), "slow_word", bus.instr, word_of(ResetPc));

    // Redirect while a response is in flight.
    set_mem(1'b0, 0, 3);
    bus.instr_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (bus.imem_gnt) found = 1'b1;
    end
    check(found, "wait_grant_seen", {31'd0, found}, 32'd1);
    step();
    redirect_to(32'h0000_0103);
    check(bus.instr_valid == 1'b0, "drop_empty", {31'd0, bus.instr_valid}, 32'd0);
    check(bus.imem_req == 1'b0, "drop_no_req", {31'd0, bus.imem_req}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (bus.imem_req) found = 1'b1;
    end
    check(found && bus.imem_addr == 32'h100, "redir_addr", bus.imem_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (bus.instr_valid) found = 1'b1;
    end
    check(found && bus.instr_pc == 32'h100, "redir_pc", bus.instr_pc, 32'h100);

    // Redirect coinciding with a response and a pop.
    set_mem(1'b0, 0, 0);
    bus.instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.imem_rvalid && bus.instr_valid) found = 1'b1;
    end
    check(found, "coincide_seen", {31'd0, found}, 32'd1);
    bus.instr_ready = 1'b1;
    redirect_to(32'h0000_2000);
    check(bus.instr_valid == 1'b0, "coincide_empty", {31'd0, bus.instr_valid}, 32'd0);
    check(bus.imem_req && bus.imem_addr == 32'h2000, "coincide_addr", bus.imem_addr, 32'h2000);

    // PC wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    check(bus.imem_addr == 32'hFFFF_FFFC, "wrap_start", bus.imem_addr, 32'hFFFF_FFFC);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (bus.imem_req && bus.imem_addr == 32'h0) found = 1'b1;
    end
    check(found, "wrap_to_zero", bus.imem_addr, 32'h0);

    // Reset during WAIT; the late response lands while idle and must be ignored.
    set_mem(1'b0, 0, 1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (bus.imem_gnt) found = 1'b1;
    end
    check(found, "rst_grant_seen", {31'd0, found}, 32'd1);
    step();
    reset = 1'b1;
    restart(ResetPc);
    step();
    check(bus.imem_req == 1'b0, "rst_wait_req", {31'd0, bus.imem_req}, 32'd0);
    check(bus.instr_valid == 1'b0, "rst_wait_valid", {31'd0, bus.instr_valid}, 32'd0);
    reset = 1'b0;
    step();
    check(bus.imem_req && bus.imem_addr == ResetPc, "rst_refetch", bus.imem_addr, ResetPc);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (bus.instr_valid) found = 1'b1;
    end
    check(found && bus.instr_pc == ResetPc, "rst_first_pc", bus.instr_pc, ResetPc);

    // Randomized traffic: variable latency, stalls and redirects.
    set_mem(1'b1, 0, 0);
    p0  = pops;
    thr = 7;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) thr = $urandom_range(1, 10);
      bus.instr_ready = ($urandom_range(0, 9) < thr);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) redirect_to(32'hFFFF_FFF0 + $urandom_range(0, 15));
        else redirect_to($urandom);
      end else begin
        step();
      end
    end
    check(pops - p0 > 200, "random_progress", pops - p0, 32'd200);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the R4 RV32I core. Holds the program counter, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned words with their PCs in a small FIFO. The FIFO head feeds decode, which hands `instr` to `immgen` and the register file. A redirect from execute (taken branch, `jal`, `jalr`) reloads the PC, flushes buffered words and discards any in-flight response.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: FIFO entries, power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request valid.
- `imem_addr`  out  32  word-aligned read address.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid; at most one per granted request, any latency ≥1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  load new PC and flush.
- `redirect_pc`  in  32  redirect target.
- `instr_valid`  out  1  FIFO head valid.
- `instr`  out  32  FIFO head instruction.
- `instr_pc`  out  32  FIFO head PC.
- `instr_ready`  in  1  decode consumes head when high with `instr_valid`.

## Operation
- Registers: `fetch_pc`, FSM state, FIFO (`DEPTH` × {pc, word}), read/write pointers, occupancy count (0..DEPTH).
- FSM states:
  - IDLE: no request.
  - REQ: `imem_req`=1, `imem_addr`=`fetch_pc`.
  - WAIT: one granted request outstanding.
  - DROP: outstanding response must be discarded.
- IDLE→REQ when count < DEPTH. Count is sampled before this cycle's pop/push.
- REQ→WAIT on `imem_gnt`. That edge latches the in-flight PC and sets `fetch_pc` += 4 (wraps mod 2^32).
- WAIT + `imem_rvalid`: push {in-flight PC, `imem_rdata`}. Next state is REQ if post-update count < DEPTH, else IDLE.
- DROP + `imem_rvalid`: discard the word; next state is REQ.
- At most one request outstanding.
- `imem_req` may deassert, and `imem_addr` may change, before grant; memory must tolerate a withdrawn request.
- Redirect (priority over all other updates this edge):
  - `fetch_pc` ← {`redirect_pc`[31:2], 2'b00}.
  - FIFO emptied; a simultaneous pop is ignored.
  - State: from IDLE or REQ (gnt=0) → REQ. From REQ with `imem_gnt`=1 → DROP. From WAIT with `imem_rvalid`=0 → DROP. From WAIT with `imem_rvalid`=1 → REQ, and the word is not pushed. From DROP with `imem_rvalid`=0 → DROP. From DROP with `imem_rvalid`=1 → REQ.
- Output side: `instr_valid` = count≠0; `instr`/`instr_pc` show the head. Pop on `instr_valid` & `instr_ready`. A push and a pop in the same cycle leave count unchanged.
- When `instr_valid`=0, `instr`/`instr_pc` are don't-care; the bench must not check them.

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, state IDLE, count 0, pointers 0, `imem_req`=0, `instr_valid`=0.
- First cycle after reset deasserts: IDLE→REQ evaluates, so `imem_req`=1 with `imem_addr`=`RESET_PC` in cycle 1.
- Push visible as `instr_valid`=1 the cycle after `imem_rvalid`.
- With 1-cycle memory (grant immediate, rvalid next cycle): one instruction per 2 cycles. Reset-deassert to first `instr_valid` is 3 cycles.
- Redirect to first new `imem_req`: 1 cycle (REQ path) or 1 cycle after the dropped response (DROP path).
- `reset` mid-transfer returns to reset values; a late `imem_rvalid` while in IDLE is ignored.
- Full FIFO with `instr_ready`=0: no new request; state holds IDLE.

## Test plan
- Reset then 1-cycle memory returning 32'h0000_0013 at 0x0, 0x4, 0x8, `instr_ready`=1 → `instr_pc` sequence 0x0, 0x4, 0x8, with the first `instr_valid` in cycle 3.
- `instr_ready`=0, DEPTH=2 → exactly 2 words buffered, `imem_req`=0 afterwards. Raise ready → words drain in order, then fetch resumes at 0x8.
- Memory with 4-cycle grant delay and 3-cycle response → `imem_addr` stable at 0x0 until grant, and the word is pushed with pc 0x0.
- Redirect to 32'h0000_0103 while in WAIT → the in-flight word is dropped, FIFO is empty, next `imem_addr`=0x100, and the next `instr_pc`=0x100.
- Redirect coincident with `imem_rvalid` and a valid pop → no push, FIFO is empty, next request is at the target.
- `fetch_pc`=32'hFFFF_FFFC → next address wraps to 0x0; `reset` asserted during WAIT → `imem_req`=0 and `instr_valid`=0 the next cycle.
